wb_trace_buffer: RTL and testbench

//  Sits directly downstream of the CPU core's write-back stage. Taps the debug_wb_* commit signals
//  and records every architectural register write as one trace entry in a FIFO. A checker or

---
 rtl/wb_trace_buffer_pkg.sv | 22 ++
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/wb_trace_buffer.sv | 86 ++++++++
 tb/tb_wb_trace_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer: trace entry layout and push qualifier.
package wb_trace_buffer_pkg;

  localparam int TRACE_ENTRY_WD = 73;
  localparam int TR_PC_HI       = 72;
  localparam int TR_PC_LO       = 41;
  localparam int TR_WEN_HI      = 40;
  localparam int TR_WEN_LO      = 37;
  localparam int TR_WNUM_HI     = 36;
  localparam int TR_WNUM_LO     = 32;
  localparam int TR_WDATA_HI    = 31;
  localparam int TR_WDATA_LO    = 0;

  // A commit is an architectural register write when any byte is enabled, optionally excluding $0.
  function automatic logic is_trace_write(input logic       capture_en,
                                          input logic [3:0] wen,
                                          input logic [4:0] wnum,
                                          input logic       filter_r0);
    return capture_en & (|wen) & ~(filter_r0 & (wnum == 5'd0));
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and a synchronous flush.
module sync_fifo_fwft #(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  din,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]  r_wr_ptr;
  logic [ADDR_W:0]  r_rd_ptr;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                 (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign level = r_wr_ptr - r_rd_ptr;

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_pop_ok  = pop & ~empty & ~clear;
  assign w_push_ok = push & (~full | w_pop_ok) & ~clear;

  // NOTE: non-blocking assignments on all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone decide which words are valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[ADDR_W-1:0]] <= din;
  end

  assign dout = empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/wb_trace_buffer.sv
// Records every committed register write from the write-back stage into a drainable trace FIFO.
module wb_trace_buffer
  import wb_trace_buffer_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int DROP_W    = 16,
  parameter  bit FILTER_R0 = 1'b1,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              capture_en,
  input  logic [31:0]       debug_wb_pc,
  input  logic [3:0]        debug_wb_rf_wen,
  input  logic [4:0]        debug_wb_rf_wnum,
  input  logic [31:0]       debug_wb_rf_wdata,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_pc,
  output logic [3:0]        trace_wen,
  output logic [4:0]        trace_wnum,
  output logic [31:0]       trace_wdata,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  logic [TRACE_ENTRY_WD-1:0] w_din;
  logic [TRACE_ENTRY_WD-1:0] w_dout;
  logic                      w_push;
  logic                      w_pop;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_drop;
  logic                      r_overflow;
  logic [DROP_W-1:0]         r_drop_cnt;

  assign w_push = is_trace_write(capture_en, debug_wb_rf_wen, debug_wb_rf_wnum, FILTER_R0);
  assign w_pop  = trace_valid & trace_ready;
  // clear wins over a simultaneous push, so a push lost to clear is never counted as a drop.
  assign w_drop = w_push & w_full & ~w_pop & ~clear;

  assign w_din[TR_PC_HI:TR_PC_LO]       = debug_wb_pc;
  assign w_din[TR_WEN_HI:TR_WEN_LO]     = debug_wb_rf_wen;
  assign w_din[TR_WNUM_HI:TR_WNUM_LO]   = debug_wb_rf_wnum;
  assign w_din[TR_WDATA_HI:TR_WDATA_LO] = debug_wb_rf_wdata;

  sync_fifo_fwft #(
    .WIDTH (TRACE_ENTRY_WD),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign trace_valid = ~w_empty;
  assign trace_pc    = w_dout[TR_PC_HI:TR_PC_LO];
  assign trace_wen   = w_dout[TR_WEN_HI:TR_WEN_LO];
  assign trace_wnum  = w_dout[TR_WNUM_HI:TR_WNUM_LO];
  assign trace_wdata = w_dout[TR_WDATA_HI:TR_WDATA_LO];
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Scoreboard bench for wb_trace_buffer: driver pushes expected entries, negedge monitor compares.
module tb_wb_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        capture_en;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [3:0]  trace_wen;
  logic [4:0]  trace_wnum;
  logic [31:0] trace_wdata;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  logic        r0_valid;
  logic [31:0] r0_pc;
  logic [3:0]  r0_wen;
  logic [4:0]  r0_wnum;
  logic [31:0] r0_wdata;
  logic [2:0]  r0_level;
  logic        r0_overflow;
  logic [15:0] r0_drop_cnt;

  wb_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W), .FILTER_R0(1'b1)) u_dut (
    .clk(clk), .rst(rst), .clear(clear), .capture_en(capture_en),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_wen(trace_wen), .trace_wnum(trace_wnum),
    .trace_wdata(trace_wdata), .level(level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  // Second instance records $0 writes; only its response to the filter case is checked.
  wb_trace_buffer #(.DEPTH(4), .DROP_W(DROP_W), .FILTER_R0(1'b0)) u_dut_r0 (
    .clk(clk), .rst(rst), .clear(clear), .capture_en(capture_en),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_valid(r0_valid), .trace_ready(trace_ready),
    .trace_pc(r0_pc), .trace_wen(r0_wen), .trace_wnum(r0_wnum),
    .trace_wdata(r0_wdata), .level(r0_level), .overflow(r0_overflow), .drop_cnt(r0_drop_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          mon_en  = 1'b0;

  logic [72:0] q[$];
  int          m_level = 0;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_drop  = '0;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [72:0] dut_payload();
    return {trace_pc, trace_wen, trace_wnum, trace_wdata};
  endfunction

  // Reference model, sampled at the clock edge while inputs are still stable.
  task automatic model_update();
    logic qual;
    logic pop_m;
    logic acc;
    if (!rst) return;
    if (clear) begin
      q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      m_drop  = '0;
      return;
    end
    qual  = capture_en && (debug_wb_rf_wen != 4'd0) && (debug_wb_rf_wnum != 5'd0);
    pop_m = trace_ready && (m_level > 0);
    acc   = qual && ((m_level < DEPTH) || pop_m);
    if (acc) q.push_back({debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata});
    else if (qual) begin
      m_ovf = 1'b1;
      if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
    end
    m_level = m_level + (acc ? 1 : 0) - (pop_m ? 1 : 0);
  endtask

  // Monitor: compares every visible output against the model and retires popped entries.
  always @(negedge clk) begin
    if (mon_en) begin
      check("valid", trace_valid, (m_level != 0));
      check("level", level, m_level[4:0]);
      check("overflow", overflow, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      if (trace_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_entry: got %h expected none", dut_payload());
        end else begin
          check("payload", dut_payload(), q[0]);
          if (trace_ready) void'(q.pop_front());
        end
      end else begin
        check("empty_payload", dut_payload(), 73'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic cap, input logic [31:0] pc, input logic [3:0] wen,
                       input logic [4:0] wnum, input logic [31:0] wdata, input logic rdy);
    capture_en        = cap;
    debug_wb_pc       = pc;
    debug_wb_rf_wen   = wen;
    debug_wb_rf_wnum  = wnum;
    debug_wb_rf_wdata = wdata;
    trace_ready       = rdy;
    tick();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b1, 32'h0, 4'h0, 5'd0, 32'h0, rdy);
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      drive(1'b1, base + 32'(4 * i), 4'hF, 5'(i % 31 + 1), 32'hA000_0000 + base + 32'(i), 1'b0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; capture_en = 1'b1; trace_ready = 1'b0;
    debug_wb_pc = '0; debug_wb_rf_wen = '0; debug_wb_rf_wnum = '0; debug_wb_rf_wdata = '0;
    tick(); tick();
    check("rst_valid", trace_valid, 1'b0);
    check("rst_level", level, 5'd0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_drop_cnt", drop_cnt, 16'd0);
    check("rst_payload", dut_payload(), 73'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    // 1: single entry, one-cycle latency, then pop
    drive(1'b1, 32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678, 1'b0);
    check("t1_level", level, 5'd1);
    check("t1_head", dut_payload(), {32'hBFC0_0000, 4'hF, 5'd8, 32'h1234_5678});
    idle(1, 1'b1);
    check("t1_level_after_pop", level, 5'd0);
    check("t1_valid_after_pop", trace_valid, 1'b0);

    // 2: push qualifier
    drive(1'b1, 32'h100, 4'h0, 5'd3, 32'h1, 1'b0);
    drive(1'b1, 32'h104, 4'hF, 5'd0, 32'h2, 1'b0);
    drive(1'b0, 32'h108, 4'hF, 5'd5, 32'h3, 1'b0);
    check("t2_level", level, 5'd0);
    check("t2_r0_level", r0_level, 3'd1);
    check("t2_r0_head", {r0_pc, r0_wen, r0_wnum, r0_wdata}, {32'h104, 4'hF, 5'd0, 32'h2});

    // 3: fill, overflow by 3, drain in order
    fill(16, 32'h1000);
    check("t3_full_level", level, 5'd16);
    check("t3_no_overflow", overflow, 1'b0);
    fill(3, 32'h2000);
    check("t3_overflow", overflow, 1'b1);
    check("t3_drop_cnt", drop_cnt, 16'd3);
    idle(16, 1'b1);
    check("t3_drained", level, 5'd0);

    // 4: full with simultaneous push and pop across pointer wrap
    fill(16, 32'h3000);
    for (int i = 0; i < 40; i++)
      drive(1'b1, 32'h4000 + 32'(4 * i), 4'h3, 5'(i % 31 + 1), 32'h5000 + 32'(i), 1'b1);
    check("t4_level", level, 5'd16);
    check("t4_drop_cnt", drop_cnt, 16'd3);
    idle(16, 1'b1);

    // 5: head held stable under backpressure, then random traffic
    drive(1'b1, 32'h6000, 4'h1, 5'd9, 32'hCAFE_F00D, 1'b0);
    idle(5, 1'b0);
    check("t5_held_head", dut_payload(), {32'h6000, 4'h1, 5'd9, 32'hCAFE_F00D});
    idle(1, 1'b1);
    for (int i = 0; i < 10000; i++)
      drive(($urandom % 8) != 0, $urandom, 4'($urandom_range(0, 15)), 5'($urandom % 32),
            $urandom, 1'($urandom % 2));
    idle(20, 1'b1);

    // 6: clear with push and pop while level=7, overflow=1
    clear = 1'b1; idle(1, 1'b0); clear = 1'b0;
    fill(17, 32'h7000);
    idle(9, 1'b1);
    check("t6_level_before", level, 5'd7);
    check("t6_ovf_before", overflow, 1'b1);
    clear = 1'b1;
    drive(1'b1, 32'h8000, 4'hF, 5'd4, 32'h8888, 1'b1);
    clear = 1'b0;
    check("t6_level", level, 5'd0);
    check("t6_overflow", overflow, 1'b0);
    check("t6_drop_cnt", drop_cnt, 16'd0);
    check("t6_valid", trace_valid, 1'b0);
    idle(2, 1'b1);

    // 6b: asynchronous reset mid-stream
    fill(3, 32'h9000);
    #3;
    rst = 1'b0;
    q.delete(); m_level = 0; m_ovf = 1'b0; m_drop = '0;
    #1;
    check("arst_valid", trace_valid, 1'b0);
    check("arst_level", level, 5'd0);
    check("arst_payload", dut_payload(), 73'd0);
    check("arst_overflow", overflow, 1'b0);
    tick();
    rst = 1'b1;
    idle(3, 1'b1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
